// File: rtl/spi_regmap_irq.sv
// Register map between the SPI slave memory port and user logic: config (optional
// shadow/commit), live status, sticky W1C events with masks, combined IRQ and ID.
module spi_regmap_irq #(
  parameter int                    ADDR_WIDTH     = 7,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    NUM_CONFIG_REG = 12,
  parameter int                    NUM_STATUS_REG = 4,
  parameter int                    NUM_IRQ_REG    = 2,
  parameter bit                    SHADOW_EN      = 1'b0,
  parameter logic [DATA_WIDTH-1:0] CONFIG_RESET   = 8'h00,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE       = 8'hA5
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_n,
  input  logic [ADDR_WIDTH-1:0]                 addr_i,
  input  logic [DATA_WIDTH-1:0]                 write_data_i,
  input  logic                                  write_en_i,
  input  logic                                  read_en_i,
  output logic [DATA_WIDTH-1:0]                 read_data_o,
  output logic [DATA_WIDTH*NUM_CONFIG_REG-1:0]  config_bus_o,
  input  logic [DATA_WIDTH*NUM_STATUS_REG-1:0]  status_bus_i,
  input  logic [DATA_WIDTH*NUM_IRQ_REG-1:0]     event_i,
  output logic                                  irq_o,
  output logic                                  commit_pulse_o
);

  localparam int unsigned NC          = NUM_CONFIG_REG;
  localparam int unsigned NS          = NUM_STATUS_REG;
  localparam int unsigned NI          = NUM_IRQ_REG;
  localparam int unsigned ST_BASE     = NC;
  localparam int unsigned EV_BASE     = NC + NS;
  localparam int unsigned MK_BASE     = EV_BASE + NI;
  localparam int unsigned COMMIT_ADDR = MK_BASE + NI;
  localparam int unsigned ID_ADDR     = COMMIT_ADDR + 1;
  localparam int          EW          = DATA_WIDTH * NUM_IRQ_REG;

  logic [1:0]            wr_sync, rd_sync;
  logic                  wr_prev, rd_prev, wr_stb, rd_stb;
  logic [EW-1:0]         ev_s0, ev_s1, ev_prev, ev_det;
  logic [DATA_WIDTH-1:0] cfg_q    [NC];
  logic [DATA_WIDTH-1:0] shd_q    [NC];
  logic [DATA_WIDTH-1:0] sticky_q [NI];
  logic [DATA_WIDTH-1:0] mask_q   [NI];
  logic [DATA_WIDTH-1:0] rd_val;
  logic [31:0]           a;
  logic                  irq_any;

  assign a = 32'(addr_i);

  for (genvar g = 0; g < NUM_CONFIG_REG; g++) begin : g_bus
    assign config_bus_o[g*DATA_WIDTH +: DATA_WIDTH] = cfg_q[g];
  end

  always_comb begin
    irq_any = 1'b0;
    for (int i = 0; i < NUM_IRQ_REG; i++) irq_any = irq_any | (|(sticky_q[i] & mask_q[i]));
  end

  // Read mux; COMMIT and unmapped addresses fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_CONFIG_REG; k++)
      if (a == 32'(k)) rd_val = SHADOW_EN ? shd_q[k] : cfg_q[k];
    for (int k = 0; k < NUM_STATUS_REG; k++)
      if (a == 32'(ST_BASE + k)) rd_val = status_bus_i[k*DATA_WIDTH +: DATA_WIDTH];
    for (int i = 0; i < NUM_IRQ_REG; i++) begin
      if (a == 32'(EV_BASE + i)) rd_val = sticky_q[i];
      if (a == 32'(MK_BASE + i)) rd_val = mask_q[i];
    end
    if (a == ID_ADDR) rd_val = ID_VALUE;
  end

  always_ff @(posedge clk_i or negedge rstn_n) begin
    if (!rstn_n) begin
      wr_sync        <= '0;
      rd_sync        <= '0;
      wr_prev        <= 1'b0;
      rd_prev        <= 1'b0;
      wr_stb         <= 1'b0;
      rd_stb         <= 1'b0;
      ev_s0          <= '0;
      ev_s1          <= '0;
      ev_prev        <= '0;
      ev_det         <= '0;
      read_data_o    <= '0;
      irq_o          <= 1'b0;
      commit_pulse_o <= 1'b0;
      for (int k = 0; k < NUM_CONFIG_REG; k++) begin
        cfg_q[k] <= CONFIG_RESET;
        shd_q[k] <= CONFIG_RESET;
      end
      for (int i = 0; i < NUM_IRQ_REG; i++) begin
        sticky_q[i] <= '0;
        mask_q[i]   <= '0;
      end
    end else begin
      // Strobes: two sync stages, then a registered rising-edge pulse acted on the next edge.
      wr_sync <= {wr_sync[0], write_en_i};
      rd_sync <= {rd_sync[0], read_en_i};
      wr_prev <= wr_sync[1];
      rd_prev <= rd_sync[1];
      wr_stb  <= wr_sync[1] & ~wr_prev;
      rd_stb  <= rd_sync[1] & ~rd_prev;
      ev_s0   <= event_i;
      ev_s1   <= ev_s0;
      ev_prev <= ev_s1;
      ev_det  <= ev_s1 & ~ev_prev;

      commit_pulse_o <= 1'b0;
      irq_o          <= irq_any;
      if (rd_stb) read_data_o <= rd_val;

      for (int k = 0; k < NUM_CONFIG_REG; k++) begin
        if (wr_stb && a == 32'(k)) begin
          shd_q[k] <= write_data_i;
          if (!SHADOW_EN) cfg_q[k] <= write_data_i;
        end
      end
      if (SHADOW_EN && wr_stb && a == COMMIT_ADDR && write_data_i[0]) begin
        for (int k = 0; k < NUM_CONFIG_REG; k++) cfg_q[k] <= shd_q[k];
        commit_pulse_o <= 1'b1;
      end

      // A fresh event edge wins over a same-cycle write-1-to-clear.
      for (int i = 0; i < NUM_IRQ_REG; i++) begin
        sticky_q[i] <= (sticky_q[i] &
                        ~((wr_stb && a == 32'(EV_BASE + i)) ? write_data_i : '0))
                       | ev_det[i*DATA_WIDTH +: DATA_WIDTH];
        if (wr_stb && a == 32'(MK_BASE + i)) mask_q[i] <= write_data_i;
      end
    end
  end

endmodule

// File: tb/tb_spi_regmap_irq.sv
// Bench for spi_regmap_irq: one direct-write and one shadow/commit instance share
// all inputs and are compared against a register-level model of the map.
module tb_spi_regmap_irq;

  logic        clk_i = 1'b0;
  logic        rstn_n = 1'b0;
  logic [6:0]  addr_i = '0;
  logic [7:0]  write_data_i = '0;
  logic        write_en_i = 1'b0;
  logic        read_en_i = 1'b0;
  logic [31:0] status_bus_i = '0;
  logic [15:0] event_i = '0;

  logic [7:0]  rd_d, rd_s;
  logic [95:0] bus_d, bus_s;
  logic        irq_d, irq_s, cp_d, cp_s;

  int vectors = 0;
  int miscompares = 0;

  // Model state: cfg_d for the direct instance, shd_s/cfg_s for the shadow instance.
  logic [7:0] cfg_d [12];
  logic [7:0] shd_s [12];
  logic [7:0] cfg_s [12];
  logic [7:0] sticky_m [2];
  logic [7:0] mask_m [2];

  always #5 clk_i = ~clk_i;

  spi_regmap_irq #(.SHADOW_EN(1'b0)) dut_d (
    .clk_i(clk_i), .rstn_n(rstn_n), .addr_i(addr_i), .write_data_i(write_data_i),
    .write_en_i(write_en_i), .read_en_i(read_en_i), .read_data_o(rd_d),
    .config_bus_o(bus_d), .status_bus_i(status_bus_i), .event_i(event_i),
    .irq_o(irq_d), .commit_pulse_o(cp_d));

  spi_regmap_irq #(.SHADOW_EN(1'b1)) dut_s (
    .clk_i(clk_i), .rstn_n(rstn_n), .addr_i(addr_i), .write_data_i(write_data_i),
    .write_en_i(write_en_i), .read_en_i(read_en_i), .read_data_o(rd_s),
    .config_bus_o(bus_s), .status_bus_i(status_bus_i), .event_i(event_i),
    .irq_o(irq_s), .commit_pulse_o(cp_s));

  function automatic void reset_model();
    for (int k = 0; k < 12; k++) begin cfg_d[k] = 8'h00; shd_s[k] = 8'h00; cfg_s[k] = 8'h00; end
    for (int i = 0; i < 2; i++) begin sticky_m[i] = 8'h00; mask_m[i] = 8'h00; end
  endfunction

  function automatic logic [7:0] model_read(input bit sh, input int a);
    if (a < 12) return sh ? shd_s[a] : cfg_d[a];
    if (a < 16) return status_bus_i[(a-12)*8 +: 8];
    if (a < 18) return sticky_m[a-16];
    if (a < 20) return mask_m[a-18];
    if (a == 21) return 8'hA5;
    return 8'h00;
  endfunction

  function automatic void model_write(input int a, input logic [7:0] d);
    if (a < 12) begin cfg_d[a] = d; shd_s[a] = d; end
    else if (a == 16 || a == 17) sticky_m[a-16] = sticky_m[a-16] & ~d;
    else if (a == 18 || a == 19) mask_m[a-18] = d;
    else if (a == 20 && d[0]) for (int k = 0; k < 12; k++) cfg_s[k] = shd_s[k];
  endfunction

  function automatic logic [95:0] model_bus(input bit sh);
    logic [95:0] v;
    for (int k = 0; k < 12; k++) v[k*8 +: 8] = sh ? cfg_s[k] : cfg_d[k];
    return v;
  endfunction

  function automatic logic model_irq();
    return |(sticky_m[0] & mask_m[0]) || |(sticky_m[1] & mask_m[1]);
  endfunction

  task automatic check96(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check96({tag, " bus_d"}, bus_d, model_bus(1'b0));
    check96({tag, " bus_s"}, bus_s, model_bus(1'b1));
    check1({tag, " irq_d"}, irq_d, model_irq());
    check1({tag, " irq_s"}, irq_s, model_irq());
  endtask

  task automatic start_access(input bit wr, input int a, input logic [7:0] d);
    @(negedge clk_i);
    addr_i = 7'(a);
    write_data_i = d;
    if (wr) write_en_i = 1'b1;
    else    read_en_i  = 1'b1;
  endtask

  task automatic end_access();
    @(negedge clk_i);
    write_en_i = 1'b0;
    read_en_i  = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    start_access(1'b1, a, d);
    repeat (4) @(posedge clk_i);
    end_access();
    model_write(a, d);
  endtask

  task automatic do_read(input int a);
    start_access(1'b0, a, 8'h00);
    repeat (4) @(posedge clk_i);
    #1;
    check8($sformatf("read_d a=%0d", a), rd_d, model_read(1'b0, a));
    check8($sformatf("read_s a=%0d", a), rd_s, model_read(1'b1, a));
    end_access();
  endtask

  task automatic pulse_event(input logic [15:0] bits);
    @(negedge clk_i);
    event_i = bits;
    repeat (3) @(negedge clk_i);
    event_i = '0;
    repeat (3) @(negedge clk_i);
    sticky_m[0] = sticky_m[0] | bits[7:0];
    sticky_m[1] = sticky_m[1] | bits[15:8];
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, a;
    logic [7:0] d;
    reset_model();

    // Reset values
    repeat (3) @(negedge clk_i);
    check8("reset rd_d", rd_d, 8'h00);
    check8("reset rd_s", rd_s, 8'h00);
    check1("reset cp_s", cp_s, 1'b0);
    check_all("reset");
    rstn_n = 1'b1;
    repeat (2) @(negedge clk_i);

    // ID, config defaults, unmapped
    do_read(21);
    for (int k = 0; k < 12; k++) do_read(k);
    do_read(22);

    // Direct write lands at edge 3
    start_access(1'b1, 5, 8'h3C);
    repeat (3) @(posedge clk_i);
    #1 check96("wr5 edge2 bus_d", bus_d, model_bus(1'b0));
    @(posedge clk_i);
    #1 model_write(5, 8'h3C);
    check96("wr5 edge3 bus_d", bus_d, model_bus(1'b0));
    check96("wr5 edge3 bus_s", bus_s, model_bus(1'b1));
    end_access();

    // Status address is read-only
    do_write(12, 8'hFF);
    check_all("wr status");
    do_read(12);

    // Shadow write, readback, then commit timing
    do_write(0, 8'h81);
    check_all("wr shadow");
    do_read(0);
    start_access(1'b1, 20, 8'h01);
    repeat (3) @(posedge clk_i);
    #1 check1("commit edge2 cp_s", cp_s, 1'b0);
    check96("commit edge2 bus_s", bus_s, model_bus(1'b1));
    @(posedge clk_i);
    #1 model_write(20, 8'h01);
    check1("commit edge3 cp_s", cp_s, 1'b1);
    check96("commit edge3 bus_s", bus_s, model_bus(1'b1));
    @(posedge clk_i);
    #1 check1("commit edge4 cp_s", cp_s, 1'b0);
    end_access();
    do_write(1, 8'h55);
    do_write(20, 8'hFE);
    check_all("commit bit0=0");
    do_read(20);

    // Event capture, mask, W1C
    pulse_event(16'h0008);
    do_read(16);
    check_all("event unmasked");
    do_write(18, 8'h08);
    check_all("event masked");
    start_access(1'b1, 16, 8'h08);
    repeat (4) @(posedge clk_i);
    #1 check1("w1c edge3 irq_d", irq_d, 1'b1);
    model_write(16, 8'h08);
    @(posedge clk_i);
    #1 check1("w1c edge4 irq_d", irq_d, 1'b0);
    check1("w1c edge4 irq_s", irq_s, 1'b0);
    end_access();
    do_read(16);

    // Event edge and W1C of the same bit in the same cycle: set wins
    pulse_event(16'h0008);
    @(negedge clk_i);
    addr_i = 7'd16;
    write_data_i = 8'h08;
    write_en_i = 1'b1;
    event_i = 16'h0008;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    write_en_i = 1'b0;
    event_i = '0;
    repeat (3) @(negedge clk_i);
    model_write(16, 8'h08);
    sticky_m[0] = sticky_m[0] | 8'h08;
    do_read(16);
    check_all("set wins");

    // Live status
    status_bus_i = 32'hDEADBEEF;
    for (int k = 12; k < 16; k++) do_read(k);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 4);
      a  = $urandom_range(0, 23);
      d  = 8'($urandom());
      case (op)
        0, 1: do_write(a, d);
        2: begin status_bus_i = $urandom(); do_read(a); end
        3: pulse_event(16'($urandom()));
        default: do_write(20, d);
      endcase
      check_all($sformatf("rand %0d op%0d", n, op));
    end

    // Reset in the middle of a write
    start_access(1'b1, 3, 8'hFF);
    repeat (2) @(posedge clk_i);
    #1 rstn_n = 1'b0;
    #1 reset_model();
    check8("midreset rd_d", rd_d, 8'h00);
    check8("midreset rd_s", rd_s, 8'h00);
    check1("midreset cp_s", cp_s, 1'b0);
    check_all("midreset");
    @(negedge clk_i);
    write_en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rstn_n = 1'b1;
    repeat (5) @(negedge clk_i);
    check_all("post reset");
    do_read(3);
    do_read(21);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_regmap_irq.md
# spi_regmap_irq

Parametrised second-generation register map that sits between the SPI slave memory interface and user logic. It provides read/write configuration registers with optional shadow/commit, live read-only status registers, sticky edge-captured event registers with write-1-to-clear, per-bit interrupt masks, a combined interrupt output and a constant ID register. All SPI-side strobes are synchronised into `clk_i` inside the block.

## Interface
- `ADDR_WIDTH`, 7: address width.
- `DATA_WIDTH`, 8: register width.
- `NUM_CONFIG_REG`, 12: number of config registers (NC).
- `NUM_STATUS_REG`, 4: number of status registers (NS).
- `NUM_IRQ_REG`, 2: number of event/mask register pairs (NI).
- `SHADOW_EN`, 0: 1 means config writes land in a shadow copy and reach `config_bus_o` only on commit.
- `CONFIG_RESET`, 8'h00: reset value of every config and shadow register.
- `ID_VALUE`, 8'hA5: constant returned by the ID register.

Ports:
- `clk_i`  in  1  system clock.
- `rstn_n`  in  1  reset, asynchronous, active-low; clears all state.
- `addr_i`  in  ADDR_WIDTH  register address from the SPI interface, stable while a strobe is high.
- `write_data_i`  in  DATA_WIDTH  write data, stable while `write_en_i` is high.
- `write_en_i`  in  1  write strobe, SCK domain, level-high per access.
- `read_en_i`  in  1  read strobe, SCK domain, level-high per access.
- `read_data_o`  out  DATA_WIDTH  registered read data.
- `config_bus_o`  out  DATA_WIDTH*NC  config register contents; register k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `status_bus_i`  in  DATA_WIDTH*NS  live status, same packing.
- `event_i`  in  DATA_WIDTH*NI  asynchronous event lines.
- `irq_o`  out  1  registered OR of (sticky & mask).
- `commit_pulse_o`  out  1  one-cycle pulse when a commit updates `config_bus_o`.

## Operation
- Address map, with base offsets derived from the parameters:
  - 0..NC-1: config registers, R/W.
  - NC..NC+NS-1: status registers, RO.
  - next NI addresses: sticky event registers, read, or write-1-to-clear.
  - next NI addresses: mask registers, R/W.
  - next address: COMMIT, write-only; reads return 0.
  - next address: ID, RO.
  - Requirement: NC+NS+2*NI+2 ≤ 2^ADDR_WIDTH.
- Unmapped or read-only addresses: writes are ignored; unmapped reads return 0.
- Strobe synchronisation:
  - `write_en_i` and `read_en_i` each pass through a 2-FF synchroniser followed by a rising-edge detector.
  - `addr_i` and `write_data_i` are sampled on the detected edge. Protocol guarantees they are stable by then.
- Config write:
  - SHADOW_EN=0: the target config register updates directly.
  - SHADOW_EN=1: the shadow register updates. A write to COMMIT with data bit0=1 copies all shadows to the config registers and pulses `commit_pulse_o`. Bit0=0 is ignored.
  - Reading a config address with SHADOW_EN=1 returns the shadow value.
- Event capture:
  - Each `event_i` bit passes through a 2-FF synchroniser and rising-edge detector.
  - A detected edge sets the sticky bit.
  - Writing 1 to a sticky bit clears it; writing 0 leaves it unchanged.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- `irq_o` = registered |(sticky & mask) across all NI registers.
- `read_data_o` holds its value until the next detected read.

## Timing
- Reset values:
  - `read_data_o` = 0, `irq_o` = 0, `commit_pulse_o` = 0.
  - Config and shadow registers = CONFIG_RESET; sticky and mask registers = 0.
  - Synchronisers are cleared.
- Write latency: `write_en_i` rises before clk edge 0; register and `config_bus_o` update at edge 3 (2 sync stages + edge detect).
- Commit: COMMIT write detected at edge 3. `config_bus_o` updates and `commit_pulse_o` is high for exactly one cycle after edge 3.
- Read latency: `read_data_o` is valid after edge 3 following the rise of `read_en_i`. System constraint: `clk_i` ≥ 4× SCK, so data is ready before the first SDO bit.
- Event: sticky bit is set at edge 3 after `event_i` rises; `irq_o` follows one edge later (edge 4).
- A strobe held high generates exactly one access. A new access requires the strobe to return low for ≥ 2 clk cycles.
- Reset asserted mid-access clears state immediately. No access is performed for a strobe already in the synchroniser when reset is released.

## Test plan
- Reset with defaults, then read addr 21 → 8'hA5. Read addr 0..11 → 8'h00. Read addr 22 → 8'h00.
- SHADOW_EN=0: write 8'h3C to addr 5 → `config_bus_o[47:40]` = 8'h3C at edge 3 and no other bits change. Write to addr 12 (status) → ignored.
- SHADOW_EN=1: write 8'h81 to addr 0 → `config_bus_o[7:0]` stays 8'h00 and readback = 8'h81. Write 8'h01 to addr 20 → bus = 8'h81 plus a one-cycle `commit_pulse_o`.
- Pulse `event_i[3]` → addr 16 reads 8'h08 and `irq_o` stays 0. Write 8'h08 to addr 18 → `irq_o` = 1. Write 8'h08 to addr 16 → sticky clears and `irq_o` = 0 one cycle later.
- Event edge on `event_i[3]` coincides with a W1C of the same bit → bit reads 1.
- Drive `status_bus_i` = 32'hDEADBEEF → addr 12..15 read EF, BE, AD, DE. Assert `rstn_n` low mid-write → no update occurs and all outputs read their reset values.
